ex_stage: RTL

- Execute stage; consumes the ID_EX pipeline register outputs and feeds the EX_MEM register.
- Computes ALU results, memory address and store data, and an overflow exception.
- Owns the HI/LO registers and an iterative 32-cycle divider.
- Requests a pipeline stall from Ctrl while a divide is in progress.

---
 rtl/ex_stage_pkg.sv | 54 +++++
 rtl/ex_stage_div.sv | 105 ++++++++++
 rtl/ex_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcode codes, control constants,
// divider state type and small helpers.
package ex_stage_pkg;

   localparam logic        Zero     = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam logic        Stop     = 1'b1;
   localparam logic        NoStop   = 1'b0;
   localparam logic        Valid    = 1'b1;
   localparam logic        Invalid  = 1'b0;

   localparam int unsigned DIV_CYCLES_DEF = 32;
   localparam int unsigned OVF_BIT_DEF    = 12;

   localparam logic [5:0] Nop      = 6'd0;
   localparam logic [5:0] OP_AND   = 6'd1;
   localparam logic [5:0] OP_OR    = 6'd2;
   localparam logic [5:0] OP_XOR   = 6'd3;
   localparam logic [5:0] OP_NOR   = 6'd4;
   localparam logic [5:0] OP_ADD   = 6'd5;
   localparam logic [5:0] OP_SUB   = 6'd6;
   localparam logic [5:0] OP_SLT   = 6'd7;
   localparam logic [5:0] OP_SLTU  = 6'd8;
   localparam logic [5:0] OP_SLL   = 6'd9;
   localparam logic [5:0] OP_SRL   = 6'd10;
   localparam logic [5:0] OP_SRA   = 6'd11;
   localparam logic [5:0] OP_LUI   = 6'd12;
   localparam logic [5:0] OP_LW    = 6'd13;
   localparam logic [5:0] OP_SW    = 6'd14;
   localparam logic [5:0] OP_MFHI  = 6'd15;
   localparam logic [5:0] OP_MFLO  = 6'd16;
   localparam logic [5:0] OP_MTHI  = 6'd17;
   localparam logic [5:0] OP_MTLO  = 6'd18;
   localparam logic [5:0] OP_MULT  = 6'd19;
   localparam logic [5:0] OP_MULTU = 6'd20;
   localparam logic [5:0] OP_DIV   = 6'd21;
   localparam logic [5:0] OP_DIVU  = 6'd22;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_e;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic is_div_op(input logic [5:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up on
// magnitudes, divide-by-zero short cut straight to DONE.
module div_unit
   import ex_stage_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        hold,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

   div_state_e    state;
   logic [CW-1:0] cnt;
   logic [31:0]   dvs;
   logic [31:0]   quo;
   logic [31:0]   rem;
   logic          neg_q;
   logic          neg_r;
   logic [32:0]   shifted;
   logic [32:0]   trial;

   // rem < dvs always holds, so the shifted partial remainder fits in 33 bits
   // and trial[32] alone says whether the subtraction went negative.
   always_comb begin
      shifted = {rem, quo[31]};
      trial   = shifted - {1'b0, dvs};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
         dvs   <= '0;
         quo   <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  cnt <= '0;
                  if (divisor == ZeroWord) begin
                     quo   <= '1;
                     rem   <= dividend;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= DIV_DONE;
                  end else begin
                     quo   <= abs32(dividend, signed_op);
                     dvs   <= abs32(divisor, signed_op);
                     rem   <= '0;
                     neg_q <= signed_op & (dividend[31] ^ divisor[31]);
                     neg_r <= signed_op & dividend[31];
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (cancel) begin
                  state <= DIV_IDLE;
               end else begin
                  if (trial[32]) begin
                     rem <= shifted[31:0];
                     quo <= {quo[30:0], 1'b0};
                  end else begin
                     rem <= trial[31:0];
                     quo <= {quo[30:0], 1'b1};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(DIV_CYCLES - 1)) begin
                     state <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               if (!hold) begin
                  state <= DIV_IDLE;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = ((state == DIV_IDLE) && start) || ((state == DIV_BUSY) && !cancel);
      done      = (state == DIV_DONE);
      quotient  = neg_q ? (~quo + 32'd1) : quo;
      remainder = neg_r ? (~rem + 32'd1) : rem;
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, memory address generation, overflow exception,
// HI/LO registers with multiply, and the iterative divider.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int unsigned OVF_BIT    = OVF_BIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [31:0] inst_i,
   input  logic [31:0] excptype_i,
   input  logic [5:0]  op_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] regaData_i,
   input  logic [31:0] regbData_i,
   input  logic        regcWrite_i,
   input  logic [4:0]  regcAddr_i,
   output logic [31:0] inst_o,
   output logic [31:0] excptype_o,
   output logic [5:0]  op_o,
   output logic [31:0] pc_o,
   output logic [31:0] regcData_o,
   output logic        regcWrite_o,
   output logic [4:0]  regcAddr_o,
   output logic [31:0] memAddr_o,
   output logic [31:0] memData_o,
   output logic        stallreq_o
);

   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] mem_off;
   logic [31:0] alu_res;
   logic        ovf;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        hold;
   logic        is_div;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        unused_stall;

   assign unused_stall = ^{stall[5:4], stall[2:0]};
   assign hold         = (stall[3] == Stop);
   assign is_div       = is_div_op(op_i);
   assign sum          = regaData_i + regbData_i;
   assign diff         = regaData_i - regbData_i;
   assign mem_off      = {{16{inst_i[15]}}, inst_i[15:0]};
   assign prod_s       = $signed({{32{regaData_i[31]}}, regaData_i}) *
                         $signed({{32{regbData_i[31]}}, regbData_i});
   assign prod_u       = {32'h0, regaData_i} * {32'h0, regbData_i};

   div_unit #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (is_div),
      .signed_op (op_i == OP_DIV),
      .dividend  (regaData_i),
      .divisor   (regbData_i),
      .hold      (hold),
      .cancel    (!is_div),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_comb begin
      alu_res = ZeroWord;
      ovf     = 1'b0;
      case (op_i)
         OP_AND:  alu_res = regaData_i & regbData_i;
         OP_OR:   alu_res = regaData_i | regbData_i;
         OP_XOR:  alu_res = regaData_i ^ regbData_i;
         OP_NOR:  alu_res = ~(regaData_i | regbData_i);
         OP_ADD: begin
            alu_res = sum;
            ovf     = (regaData_i[31] == regbData_i[31]) && (sum[31] != regaData_i[31]);
         end
         OP_SUB: begin
            alu_res = diff;
            ovf     = (regaData_i[31] != regbData_i[31]) && (diff[31] != regaData_i[31]);
         end
         OP_SLT:  alu_res = {31'h0, $signed(regaData_i) < $signed(regbData_i)};
         OP_SLTU: alu_res = {31'h0, regaData_i < regbData_i};
         OP_SLL:  alu_res = regbData_i << regaData_i[4:0];
         OP_SRL:  alu_res = regbData_i >> regaData_i[4:0];
         OP_SRA:  alu_res = $signed(regbData_i) >>> regaData_i[4:0];
         OP_LUI:  alu_res = {regbData_i[15:0], 16'h0};
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = ZeroWord;
      endcase
   end

   // Outputs are combinational from the inputs but forced to zero during reset.
   always_comb begin
      inst_o      = ZeroWord;
      excptype_o  = ZeroWord;
      op_o        = Nop;
      pc_o        = ZeroWord;
      regcData_o  = ZeroWord;
      regcWrite_o = Invalid;
      regcAddr_o  = '0;
      memAddr_o   = ZeroWord;
      memData_o   = ZeroWord;
      stallreq_o  = Zero;
      if (!rst) begin
         inst_o              = inst_i;
         excptype_o          = excptype_i;
         excptype_o[OVF_BIT] = excptype_i[OVF_BIT] | ovf;
         op_o                = op_i;
         pc_o                = pc_i;
         regcData_o          = alu_res;
         regcWrite_o         = regcWrite_i & ~ovf;
         regcAddr_o          = regcAddr_i;
         memAddr_o           = regaData_i + mem_off;
         memData_o           = regbData_i;
         stallreq_o          = div_busy;
      end
   end

   // HI/LO only move while EX is not held, so a stalled instruction writes once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= ZeroWord;
         lo <= ZeroWord;
      end else if (!hold) begin
         if (div_done) begin
            lo <= div_q;
            hi <= div_r;
         end else begin
            case (op_i)
               OP_MTHI:  hi <= regaData_i;
               OP_MTLO:  lo <= regaData_i;
               OP_MULT:  {hi, lo} <= prod_s;
               OP_MULTU: {hi, lo} <= prod_u;
               default: ;
            endcase
         end
      end
   end

endmodule
